// File: rtl/adder_n.sv
// -----------------------------------------------------------------------------
// adder_n
//   N-bit two's-complement / unsigned adder with a registered result and
//   status flags. One clock of latency, one result per clock, no stall.
//   O = (A + B + cin) mod 2^N, computed by a ripple-carry chain of N full-adder
//   cells; the sum and all flags are registered together in one stage, so
//   there is no combinational path from any input to any output.
//
// Parameters
//   N          operand / result width in bits (legal 2..64, default 32)
//
// Optional feature (compile-time macro ADDER_N_CIN_EN)
//   defined    : port ci exists and is added as the LSB carry-in
//   undefined  : port ci is absent and the carry-in is tied to 0
//
// Ports
//   clk        in   1  clock, all state updates on the rising edge
//   rst        in   1  synchronous active-high reset (priority over in_valid)
//   in_valid   in   1  A/B (and ci) carry operands this cycle
//   A          in   N  operand A
//   B          in   N  operand B
//   ci         in   1  carry-in (only with ADDER_N_CIN_EN)
//   O          out  N  registered sum
//   out_valid  out  1  O and flags hold a fresh result this cycle
//   co         out  1  unsigned carry-out (bit N of the full sum)
//   ovf        out  1  signed overflow
//   zero       out  1  O == 0
//   neg        out  1  O[N-1]
// -----------------------------------------------------------------------------
module adder_n #(
   parameter int N = 32'd32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
`ifdef ADDER_N_CIN_EN
   input  logic         ci,
`endif
   output logic [N-1:0] O,
   output logic         out_valid,
   output logic         co,
   output logic         ovf,
   output logic         zero,
   output logic         neg
);

   // Full-adder cell: sum bit
   function automatic logic fa_sum(input logic a, input logic b, input logic c);
      return a ^ b ^ c;
   endfunction

   // Full-adder cell: carry out (generate, or propagate an incoming carry)
   function automatic logic fa_carry(input logic a, input logic b, input logic c);
      return (a & b) | (c & (a ^ b));
   endfunction

   logic         cin_s;
   logic [N:0]   carry_s;
   logic [N-1:0] sum_s;
   logic         ovf_s;
   logic         zero_s;

   logic [N-1:0] sum_r;
   logic         valid_r;
   logic         co_r;
   logic         ovf_r;
   logic         zero_r;
   logic         neg_r;

`ifdef ADDER_N_CIN_EN
   assign cin_s = ci;
`else
   assign cin_s = 1'b0;
`endif

   assign carry_s[0] = cin_s;

   // Ripple-carry chain, one full-adder cell per bit
   for (genvar i = 0; i < N; i = i + 1) begin : g_fa
      assign sum_s[i]       = fa_sum  (A[i], B[i], carry_s[i]);
      assign carry_s[i + 1] = fa_carry(A[i], B[i], carry_s[i]);
   end

   // Signed overflow: like-signed operands producing a result of the other sign
   assign ovf_s  = (A[N-1] == B[N-1]) && (sum_s[N-1] != A[N-1]);
   assign zero_s = (sum_s == {N{1'b0}});

   // Result register: reset clears, fresh operands load sum and flags together,
   // idle cycles drop out_valid and hold the last result
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_r <= 1'b0;
         sum_r   <= {N{1'b0}};
         co_r    <= 1'b0;
         ovf_r   <= 1'b0;
         zero_r  <= 1'b1;
         neg_r   <= 1'b0;
      end else if (in_valid) begin
         valid_r <= 1'b1;
         sum_r   <= sum_s;
         co_r    <= carry_s[N];
         ovf_r   <= ovf_s;
         zero_r  <= zero_s;
         neg_r   <= sum_s[N-1];
      end else begin
         // out_valid depends on in_valid only, so X on idle operands cannot reach it
         valid_r <= 1'b0;
      end
   end

   assign O         = sum_r;
   assign out_valid = valid_r;
   assign co        = co_r;
   assign ovf       = ovf_r;
   assign zero      = zero_r;
   assign neg       = neg_r;

endmodule

// File: tb/tb_adder_n.sv
// -----------------------------------------------------------------------------
// tb_adder_n
//   Self-checking bench for adder_n at N=5. Expected results are computed by an
//   integer model when operands are driven, pushed to a scoreboard queue and
//   popped when the DUT presents its registered result one cycle later.
//   Build with +define+ADDER_N_CIN_EN to exercise the carry-in variant.
// -----------------------------------------------------------------------------
module tb_adder_n;

   localparam int N = 5;
`ifdef ADDER_N_CIN_EN
   localparam logic CIN_EN = 1'b1;
`else
   localparam logic CIN_EN = 1'b0;
`endif

   typedef struct packed {
      logic [N-1:0] o;
      logic         co;
      logic         ovf;
      logic         zero;
      logic         neg;
   } res_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic [N-1:0] A;
   logic [N-1:0] B;
`ifdef ADDER_N_CIN_EN
   logic         ci;
`endif
   logic [N-1:0] O;
   logic         out_valid;
   logic         co;
   logic         ovf;
   logic         zero;
   logic         neg;

   res_t exp_q[$];
   res_t held;
   logic exp_valid;
   int   n_cmp = 0;
   int   n_err = 0;

   adder_n #(.N(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .A         (A),
      .B         (B),
`ifdef ADDER_N_CIN_EN
      .ci        (ci),
`endif
      .O         (O),
      .out_valid (out_valid),
      .co        (co),
      .ovf       (ovf),
      .zero      (zero),
      .neg       (neg)
   );

   always #5 clk = ~clk;

   // Integer reference: unsigned sum for O/co, signed sum range for ovf
   function automatic res_t model(input logic [N-1:0] a, input logic [N-1:0] b, input logic c);
      res_t r;
      int   us;
      int   sa;
      int   sb;
      int   ss;
      int   m;
      us     = int'(a) + int'(b) + int'(c);
      sa     = a[N-1] ? int'(a) - (1 << N) : int'(a);
      sb     = b[N-1] ? int'(b) - (1 << N) : int'(b);
      ss     = sa + sb + int'(c);
      m      = us % (1 << N);
      r.o    = m[N-1:0];
      r.co   = (us >= (1 << N));
      r.ovf  = (ss > (1 << (N - 1)) - 1) || (ss < -(1 << (N - 1)));
      r.zero = (m == 0);
      r.neg  = (m >= (1 << (N - 1)));
      return r;
   endfunction

   // Drive one cycle of stimulus, then advance the expected output state
   task automatic drive(input logic r, input logic v, input logic [N-1:0] a,
                        input logic [N-1:0] b, input logic c);
      rst      = r;
      in_valid = v;
      A        = a;
      B        = b;
`ifdef ADDER_N_CIN_EN
      ci       = c;
`endif
      if (v && !r) exp_q.push_back(model(a, b, CIN_EN & c));
      @(posedge clk);
      #1;
      if (r) begin
         exp_valid = 1'b0;
         held      = '{o: '0, co: 1'b0, ovf: 1'b0, zero: 1'b1, neg: 1'b0};
         exp_q.delete();
      end else if (v) begin
         exp_valid = 1'b1;
         if (exp_q.size() > 0) held = exp_q.pop_front();
      end else begin
         exp_valid = 1'b0;
      end
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b0, 5'd9, 5'd9, 1'b0);
         n_cmp++;
         if ({out_valid, O, co, ovf, zero, neg} !== {1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL reset[%0d]: got ov=%b O=%0d co=%b ovf=%b z=%b n=%b, want ov=0 O=0 co=0 ovf=0 z=1 n=0",
                     i, out_valid, O, co, ovf, zero, neg);
         end
      end
   endtask

   task automatic test_sequence();
      logic [N-1:0] k5;
      for (int k = 1; k <= 9; k++) begin
         k5 = N'(k);
         drive(1'b0, 1'b1, k5, k5, 1'b0);
         n_cmp++;
         if ({out_valid, O, co, ovf, zero, neg} !== {exp_valid, held}) begin
            n_err++;
            $display("FAIL seq[%0d]: got ov=%b O=%0d co=%b ovf=%b z=%b n=%b, want ov=%b O=%0d co=%b ovf=%b z=%b n=%b",
                     k, out_valid, O, co, ovf, zero, neg, exp_valid, held.o, held.co, held.ovf, held.zero, held.neg);
         end
         n_cmp++;
         if (!CIN_EN && ({out_valid, O, co} !== {1'b1, N'(2 * k), 1'b0})) begin
            n_err++;
            $display("FAIL seq_const[%0d]: got ov=%b O=%0d co=%b, want ov=1 O=%0d co=0",
                     k, out_valid, O, co, 2 * k);
         end
      end
   endtask

   task automatic test_wrap_flags();
      logic [N-1:0] ta[8] = '{5'd31, 5'd16, 5'd15, 5'd16, 5'd0, 5'd8, 5'd24, 5'd17};
      logic [N-1:0] tb[8] = '{5'd1,  5'd16, 5'd1,  5'd31, 5'd0, 5'd8, 5'd24, 5'd14};
      for (int i = 0; i < 8; i++) begin
         drive(1'b0, 1'b1, ta[i], tb[i], 1'b0);
         n_cmp++;
         if ({out_valid, O, co, ovf, zero, neg} !== {exp_valid, held}) begin
            n_err++;
            $display("FAIL wrap[%0d] %0d+%0d: got ov=%b O=%0d co=%b ovf=%b z=%b n=%b, want ov=%b O=%0d co=%b ovf=%b z=%b n=%b",
                     i, ta[i], tb[i], out_valid, O, co, ovf, zero, neg,
                     exp_valid, held.o, held.co, held.ovf, held.zero, held.neg);
         end
      end
      // Explicit corner: 15+1 -> 16, negative, signed overflow, no carry
      drive(1'b0, 1'b1, 5'd15, 5'd1, 1'b0);
      n_cmp++;
      if (!CIN_EN && ({O, co, ovf, zero, neg} !== {5'd16, 1'b0, 1'b1, 1'b0, 1'b1})) begin
         n_err++;
         $display("FAIL wrap_15p1: got O=%0d co=%b ovf=%b z=%b n=%b, want O=16 co=0 ovf=1 z=0 n=1",
                  O, co, ovf, zero, neg);
      end
   endtask

   task automatic test_reset_mid();
      drive(1'b0, 1'b1, 5'd7, 5'd8, 1'b0);
      drive(1'b1, 1'b1, 5'd3, 5'd3, 1'b0);
      n_cmp++;
      if ({out_valid, O, zero} !== {1'b0, 5'd0, 1'b1}) begin
         n_err++;
         $display("FAIL reset_mid: got ov=%b O=%0d z=%b, want ov=0 O=0 z=1", out_valid, O, zero);
      end
      drive(1'b0, 1'b1, 5'd3, 5'd3, 1'b0);
      n_cmp++;
      if (!CIN_EN && ({out_valid, O, zero} !== {1'b1, 5'd6, 1'b0})) begin
         n_err++;
         $display("FAIL reset_mid_after: got ov=%b O=%0d z=%b, want ov=1 O=6 z=0", out_valid, O, zero);
      end
   endtask

   task automatic test_hold();
      drive(1'b0, 1'b1, 5'd7, 5'd7, 1'b0);
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if ({out_valid, O, co, ovf, zero, neg} !== {exp_valid, held}) begin
            n_err++;
            $display("FAIL hold[%0d]: got ov=%b O=%0d co=%b ovf=%b z=%b n=%b, want ov=%b O=%0d co=%b ovf=%b z=%b n=%b",
                     i, out_valid, O, co, ovf, zero, neg, exp_valid, held.o, held.co, held.ovf, held.zero, held.neg);
         end
         if (i < 3) drive(1'b0, 1'b0, 'x, 'x, 1'b0);
      end
      n_cmp++;
      if (!CIN_EN && ({out_valid, O} !== {1'b0, 5'd14})) begin
         n_err++;
         $display("FAIL hold_const: got ov=%b O=%0d, want ov=0 O=14", out_valid, O);
      end
   endtask

`ifdef ADDER_N_CIN_EN
   task automatic test_cin();
      logic [N-1:0] k5;
      for (int k = 6; k <= 9; k++) begin
         k5 = N'(k);
         drive(1'b0, 1'b1, k5, k5, 1'b1);
         n_cmp++;
         if ({out_valid, O, co} !== {1'b1, N'(2 * k + 1), 1'b0}) begin
            n_err++;
            $display("FAIL cin[%0d]: got ov=%b O=%0d co=%b, want ov=1 O=%0d co=0", k, out_valid, O, co, 2 * k + 1);
         end
      end
      drive(1'b0, 1'b1, 5'd31, 5'd0, 1'b1);
      n_cmp++;
      if ({out_valid, O, co, zero} !== {1'b1, 5'd0, 1'b1, 1'b1}) begin
         n_err++;
         $display("FAIL cin_wrap: got ov=%b O=%0d co=%b z=%b, want ov=1 O=0 co=1 z=1", out_valid, O, co, zero);
      end
   endtask
`endif

   task automatic test_back_to_back();
      logic         v;
      logic [N-1:0] a;
      logic [N-1:0] b;
      logic         c;
      for (int i = 0; i < 40; i++) begin
         v = ($urandom_range(0, 3) != 0);
         a = N'($urandom);
         b = N'($urandom);
         c = 1'($urandom);
         drive(1'b0, v, a, b, c);
         n_cmp++;
         if ({out_valid, O, co, ovf, zero, neg} !== {exp_valid, held}) begin
            n_err++;
            $display("FAIL b2b[%0d] v=%b %0d+%0d: got ov=%b O=%0d co=%b ovf=%b z=%b n=%b, want ov=%b O=%0d co=%b ovf=%b z=%b n=%b",
                     i, v, a, b, out_valid, O, co, ovf, zero, neg,
                     exp_valid, held.o, held.co, held.ovf, held.zero, held.neg);
         end
      end
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      A         = '0;
      B         = '0;
`ifdef ADDER_N_CIN_EN
      ci        = 1'b0;
`endif
      exp_valid = 1'b0;
      held      = '0;
      test_reset();
      test_sequence();
      test_wrap_flags();
      test_reset_mid();
      test_hold();
`ifdef ADDER_N_CIN_EN
      test_cin();
`endif
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/adder_n.md
Name: adder_n

Overview:
- Parameterised N-bit two's-complement/unsigned adder with a registered result and status flags.
- Integer-arithmetic building block in the CPU datapath (ALU add path, address/PC increment).
- Computes O = A + B (+ optional carry-in), modulo 2^N, with one clock of latency and a valid qualifier.

Parameters:
- N, default 32, operand and result width in bits; legal range 2..64.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  A/B (and ci) are valid this cycle; sampled on rising clk.
- A  input  N  operand A.
- B  input  N  operand B.
- ci  input  1  carry-in; exists only when ADDER_N_CIN_EN is defined.
- O  output  N  registered sum, (A + B + cin) mod 2^N.
- out_valid  output  1  O and flags hold a fresh result.
- co  output  1  unsigned carry-out, bit N of the full sum.
- ovf  output  1  signed overflow: A[N-1]==B[N-1] and O[N-1]!=A[N-1].
- zero  output  1  O == 0.
- neg  output  1  O[N-1].

Behaviour:
- Reset: on a rising clk with rst=1, clear O, co, ovf, neg and out_valid to 0, and set zero to 1. rst has priority over in_valid.
- Latency: 1 cycle. When in_valid=1 at edge k, O and the flags reflect those operands after edge k. out_valid=1 for exactly that cycle.
- When in_valid=0 at an edge, out_valid goes to 0. O and the flags hold their last value; do not clear them.
- Back-to-back: in_valid may be high every cycle. Throughput is one result per clock with no stall or backpressure.
- Arithmetic: form an N+1-bit internal sum {co, O} = {1'b0,A} + {1'b0,B} + cin.
  - Wrap-around is modulo 2^N and is not saturated.
  - cin = ci when the macro is defined, otherwise constant 0.
- Flags are computed from the same operands as O and registered in the same cycle. They are never stale relative to O.
- Combinational core: a ripple-carry chain of N full-adder cells (generate loop), with one register stage at the output.
  - No combinational path from inputs to outputs.
- Operands are sign-agnostic. Read co for unsigned results and ovf for signed results.
- Reset mid-stream: an operand presented on the reset edge is discarded, and out_valid stays 0 on the following cycle.
- X on A/B while in_valid=0 must not propagate to out_valid.

Optional Feature:
- Macro ADDER_N_CIN_EN.
- Defined: port ci is present, sampled with A/B under in_valid, and added as the LSB carry-in. Example: A=6, B=6, ci=1 gives O=13.
- Not defined: port ci is absent and the carry-in is tied to 0. The port list is then clk, rst, in_valid, A, B, O, out_valid, co, ovf, zero, neg.

Test Plan:
- N=5, reset then in_valid pulses with A=B=1,2,...,9 on successive cycles -> O=2,4,6,8,10,12,14,16,18 one cycle later each, co=0, out_valid high each cycle.
- N=5, A=31, B=1 -> O=0, co=1, zero=1, ovf=0; A=16, B=16 -> O=0, co=1, ovf=1, neg=0.
- N=5, A=15, B=1 -> O=16, neg=1, ovf=1, co=0; A=5'b10000, B=5'b11111 -> O=15, co=1, ovf=1.
- Assert rst=1 on the same edge as in_valid with A=3, B=3 -> next cycle out_valid=0, O=0, zero=1. Deassert rst, then A=3, B=3 -> O=6.
- in_valid=1 with A=7, B=7, then in_valid=0 for 3 cycles -> O=14 is held, out_valid is 1 for one cycle and then 0.
- ADDER_N_CIN_EN defined, N=5, ci=1: A=6,7,8,9 equal to B -> O=13,15,17,19. ci=1 with A=31, B=0 -> O=0, co=1.
